// File: rtl/tinyrisc_pkg.sv
// tinyrisc_pkg: shared TinyRISC decode definitions for the hazard unit.
//   - opcode values (bits [31:27]) and instruction field positions
//   - forwarding-select encoding and the mul/div/mod FSM state type
//   - decode helpers: writer/destination, source-operand readers and a
//     MA-over-WB forwarding picker
package tinyrisc_pkg;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_MUL  = 5'd2;
  localparam logic [4:0] OP_DIV  = 5'd3;
  localparam logic [4:0] OP_MOD  = 5'd4;
  localparam logic [4:0] OP_CMP  = 5'd5;
  localparam logic [4:0] OP_AND  = 5'd6;
  localparam logic [4:0] OP_OR   = 5'd7;
  localparam logic [4:0] OP_NOT  = 5'd8;
  localparam logic [4:0] OP_MOV  = 5'd9;
  localparam logic [4:0] OP_LSL  = 5'd10;
  localparam logic [4:0] OP_LSR  = 5'd11;
  localparam logic [4:0] OP_ASR  = 5'd12;
  localparam logic [4:0] OP_NOP  = 5'd13;
  localparam logic [4:0] OP_LD   = 5'd14;
  localparam logic [4:0] OP_ST   = 5'd15;
  localparam logic [4:0] OP_BEQ  = 5'd16;
  localparam logic [4:0] OP_BGT  = 5'd17;
  localparam logic [4:0] OP_B    = 5'd18;
  localparam logic [4:0] OP_CALL = 5'd19;
  localparam logic [4:0] OP_RET  = 5'd20;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 27;
  localparam int IMM_BIT = 26;
  localparam int RD_MSB  = 25;
  localparam int RD_LSB  = 22;
  localparam int RS1_MSB = 21;
  localparam int RS1_LSB = 18;
  localparam int RS2_MSB = 17;
  localparam int RS2_LSB = 14;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_MA   = 2'b01,
    FWD_WB   = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  function automatic logic [4:0] opcode(input logic [31:0] instr);
    return instr[OP_MSB:OP_LSB];
  endfunction

  // add..asr occupy the contiguous low opcode range
  function automatic logic is_alu(input logic [4:0] op);
    return (op <= OP_ASR);
  endfunction

  function automatic logic is_md(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

  function automatic logic is_writer(input logic [31:0] instr);
    logic [4:0] op;
    op = opcode(instr);
    return (is_alu(op) && (op != OP_CMP)) || (op == OP_LD) || (op == OP_CALL);
  endfunction

  // call implicitly writes the return-address register
  function automatic logic [3:0] dest_reg(input logic [31:0] instr, input logic [3:0] ra);
    return (opcode(instr) == OP_CALL) ? ra : instr[RD_MSB:RD_LSB];
  endfunction

  // ret's implicit ra read is presented on the rs1 path
  function automatic logic reads_rs1(input logic [31:0] instr);
    logic [4:0] op;
    op = opcode(instr);
    return (is_alu(op) && (op != OP_NOT) && (op != OP_MOV)) ||
           (op == OP_LD) || (op == OP_ST) || (op == OP_RET);
  endfunction

  function automatic logic [3:0] src1_reg(input logic [31:0] instr, input logic [3:0] ra);
    return (opcode(instr) == OP_RET) ? ra : instr[RS1_MSB:RS1_LSB];
  endfunction

  function automatic logic reads_rs2(input logic [31:0] instr);
    logic [4:0] op;
    op = opcode(instr);
    return is_alu(op) && (op != OP_NOT) && (op != OP_MOV) && !instr[IMM_BIT];
  endfunction

  function automatic logic reads_rd(input logic [31:0] instr);
    return (opcode(instr) == OP_ST);
  endfunction

  // Youngest producer wins: MA is checked before WB, so at most one bit is set
  function automatic fwd_sel_e fwd_pick(input logic rd_en, input logic [3:0] src,
                                        input logic ma_ok, input logic [3:0] ma_dst,
                                        input logic wb_ok, input logic [3:0] wb_dst);
    if (rd_en && ma_ok && (ma_dst == src)) begin
      return FWD_MA;
    end else if (rd_en && wb_ok && (wb_dst == src)) begin
      return FWD_WB;
    end else begin
      return FWD_NONE;
    end
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_md.sv
// md_stall_fsm: holds a mul/div/mod in EX for MD_LAT cycles.
//   clk, rst      : clock, synchronous active-high reset
//   vld_ex, op_ex : EX valid bit and opcode
//   md_stall      : high for the first MD_LAT-1 cycles of EX residency
module md_stall_fsm
  import tinyrisc_pkg::*;
#(
  parameter int MD_LAT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vld_ex,
  input  logic [4:0] op_ex,
  output logic       md_stall
);

  localparam int CNTW = $clog2(MD_LAT) + 1;
  localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_LOAD = (MD_LAT > 1) ? CNTW'(MD_LAT - 2) : CNT_ZERO;
  localparam logic            MULTI    = (MD_LAT > 1);

  md_state_e       state_r;
  logic [CNTW-1:0] cnt_r;
  logic            start_s;

  // single-cycle units never need to stall
  assign start_s = MULTI && vld_ex && is_md(op_ex);

  // stall request: immediate on entry, then until the counter drains
  always_comb begin
    md_stall = 1'b0;
    case (state_r)
      MD_IDLE: md_stall = start_s;
      MD_BUSY: md_stall = (cnt_r != CNT_ZERO);
      default: md_stall = 1'b0;
    endcase
  end

  // state and down-counter; the release cycle always returns to IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= MD_IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      case (state_r)
        MD_IDLE: begin
          if (start_s) begin
            state_r <= MD_BUSY;
            cnt_r   <= CNT_LOAD;
          end else begin
            state_r <= MD_IDLE;
            cnt_r   <= cnt_r;
          end
        end
        MD_BUSY: begin
          if (cnt_r != CNT_ZERO) begin
            state_r <= MD_BUSY;
            cnt_r   <= cnt_r - CNT_ONE;
          end else begin
            state_r <= MD_IDLE;
            cnt_r   <= CNT_ZERO;
          end
        end
        default: begin
          state_r <= MD_IDLE;
          cnt_r   <= CNT_ZERO;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: forwarding selects and pipeline hold/bubble/flush control
// for the 5-stage TinyRISC pipeline.
//   in : clk, rst (sync, active-high), instr_{OF,EX,MA,WB}, vld_{OF,EX,MA,WB},
//        br_taken_EX
//   out: fwd_of_rs1/2 (WB->OF), fwd_ex_rs1/2/st (00 none, 01 MA, 10 WB),
//        fwd_ma_st (WB->st data in MA), hold_IF/OF/EX, bubble_EX/MA,
//        flush_OF, stall_cycles (saturating count of hold_OF cycles)
module hazard_fwd_ctrl
  import tinyrisc_pkg::*;
#(
  parameter int NREG   = 16,
  parameter int RW     = 4,
  parameter int MD_LAT = 4,
  parameter int CW     = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   instr_OF,
  input  logic [31:0]   instr_EX,
  input  logic [31:0]   instr_MA,
  input  logic [31:0]   instr_WB,
  input  logic          vld_OF,
  input  logic          vld_EX,
  input  logic          vld_MA,
  input  logic          vld_WB,
  input  logic          br_taken_EX,
  output logic          fwd_of_rs1,
  output logic          fwd_of_rs2,
  output logic [1:0]    fwd_ex_rs1,
  output logic [1:0]    fwd_ex_rs2,
  output logic [1:0]    fwd_ex_st,
  output logic          fwd_ma_st,
  output logic          hold_IF,
  output logic          hold_OF,
  output logic          hold_EX,
  output logic          bubble_EX,
  output logic          bubble_MA,
  output logic          flush_OF,
  output logic [CW-1:0] stall_cycles
);

  localparam logic [RW-1:0] RA     = RW'(NREG - 1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic          unused_bits_s;
  logic          md_stall_s;
  logic          ld_use_s;
  logic          ex_ld_s;
  logic          ma_src_s;
  logic          wb_src_s;
  logic [RW-1:0] ma_dst_s;
  logic [RW-1:0] wb_dst_s;
  logic [CW-1:0] stall_r;

  // operand fields are not used by every stage
  assign unused_bits_s = ^{instr_OF, instr_EX, instr_MA, instr_WB};

  // a load in MA has no data yet, so it never forwards into EX
  assign ma_src_s = vld_MA && is_writer(instr_MA) && (opcode(instr_MA) != OP_LD);
  assign wb_src_s = vld_WB && is_writer(instr_WB);
  assign ma_dst_s = dest_reg(instr_MA, RA);
  assign wb_dst_s = dest_reg(instr_WB, RA);

  // forwarding selects for OF, EX and MA consumers
  always_comb begin
    fwd_of_rs1 = vld_OF && reads_rs1(instr_OF) && wb_src_s &&
                 (src1_reg(instr_OF, RA) == wb_dst_s);
    fwd_of_rs2 = vld_OF && reads_rs2(instr_OF) && wb_src_s &&
                 (instr_OF[RS2_MSB:RS2_LSB] == wb_dst_s);
    fwd_ex_rs1 = fwd_pick(vld_EX && reads_rs1(instr_EX), src1_reg(instr_EX, RA),
                          ma_src_s, ma_dst_s, wb_src_s, wb_dst_s);
    fwd_ex_rs2 = fwd_pick(vld_EX && reads_rs2(instr_EX), instr_EX[RS2_MSB:RS2_LSB],
                          ma_src_s, ma_dst_s, wb_src_s, wb_dst_s);
    fwd_ex_st  = fwd_pick(vld_EX && reads_rd(instr_EX), instr_EX[RD_MSB:RD_LSB],
                          ma_src_s, ma_dst_s, wb_src_s, wb_dst_s);
    fwd_ma_st  = vld_MA && reads_rd(instr_MA) && wb_src_s &&
                 (instr_MA[RD_MSB:RD_LSB] == wb_dst_s);
  end

  // load in EX whose destination is any operand of the OF instruction
  assign ex_ld_s  = vld_EX && (opcode(instr_EX) == OP_LD);
  assign ld_use_s = ex_ld_s && vld_OF &&
                    ((reads_rs1(instr_OF) && (src1_reg(instr_OF, RA) == instr_EX[RD_MSB:RD_LSB])) ||
                     (reads_rs2(instr_OF) && (instr_OF[RS2_MSB:RS2_LSB] == instr_EX[RD_MSB:RD_LSB])) ||
                     (reads_rd(instr_OF)  && (instr_OF[RD_MSB:RD_LSB] == instr_EX[RD_MSB:RD_LSB])));

  md_stall_fsm #(
    .MD_LAT(MD_LAT)
  ) u_md_stall_fsm (
    .clk     (clk),
    .rst     (rst),
    .vld_ex  (vld_EX),
    .op_ex   (instr_EX[OP_MSB:OP_LSB]),
    .md_stall(md_stall_s)
  );

  // control priority: md stall, then taken branch (kills ld_use), then ld_use
  always_comb begin
    hold_IF   = 1'b0;
    hold_OF   = 1'b0;
    hold_EX   = 1'b0;
    bubble_EX = 1'b0;
    bubble_MA = 1'b0;
    flush_OF  = 1'b0;
    if (md_stall_s) begin
      hold_IF   = 1'b1;
      hold_OF   = 1'b1;
      hold_EX   = 1'b1;
      bubble_MA = 1'b1;
    end else if (br_taken_EX) begin
      flush_OF  = 1'b1;
      bubble_EX = 1'b1;
    end else if (ld_use_s) begin
      hold_IF   = 1'b1;
      hold_OF   = 1'b1;
      bubble_EX = 1'b1;
    end else begin
      hold_IF   = 1'b0;
    end
  end

  // saturating count of cycles in which OF was held
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_r <= {CW{1'b0}};
    end else if (hold_OF && (stall_r != CNT_MAX)) begin
      stall_r <= stall_r + CW'(1);
    end else begin
      stall_r <= stall_r;
    end
  end

  assign stall_cycles = stall_r;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Scoreboard bench: three DUTs (MD_LAT = 4, 1, 6) share one stimulus stream.
// The driver pushes hand-computed expectations; a negedge monitor pops them.
module tb_hazard_fwd_ctrl;
  import tinyrisc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_of, i_ex, i_ma, i_wb;
  logic        v_of, v_ex, v_ma, v_wb, br;

  logic [2:0]  of1, of2, mas, hif, hof, hex, bex, bma, fof;
  logic [1:0]  exr1 [3];
  logic [1:0]  exr2 [3];
  logic [1:0]  exst [3];
  logic [15:0] sc   [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    hazard_fwd_ctrl #(
      .NREG(16), .RW(4), .MD_LAT((g == 0) ? 4 : ((g == 1) ? 1 : 6)), .CW(16)
    ) u_dut (
      .clk(clk), .rst(rst),
      .instr_OF(i_of), .instr_EX(i_ex), .instr_MA(i_ma), .instr_WB(i_wb),
      .vld_OF(v_of), .vld_EX(v_ex), .vld_MA(v_ma), .vld_WB(v_wb),
      .br_taken_EX(br),
      .fwd_of_rs1(of1[g]), .fwd_of_rs2(of2[g]),
      .fwd_ex_rs1(exr1[g]), .fwd_ex_rs2(exr2[g]), .fwd_ex_st(exst[g]),
      .fwd_ma_st(mas[g]),
      .hold_IF(hif[g]), .hold_OF(hof[g]), .hold_EX(hex[g]),
      .bubble_EX(bex[g]), .bubble_MA(bma[g]), .flush_OF(fof[g]),
      .stall_cycles(sc[g])
    );
  end

  typedef struct {
    int          id;
    logic [8:0]  fwd;   // {of1, of2, ex_rs1, ex_rs2, ex_st, ma_st}
    logic [17:0] ctrl;  // per DUT {hold_IF,hold_OF,hold_EX,bubble_EX,bubble_MA,flush_OF}
    logic [47:0] cnt;   // per DUT stall_cycles
  } exp_t;

  exp_t        sb [$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] mcnt [3];

  localparam logic [5:0] Z  = 6'b000000;
  localparam logic [5:0] MD = 6'b111010;
  localparam logic [5:0] LU = 6'b110100;
  localparam logic [5:0] BR = 6'b000101;

  function automatic logic [31:0] enc(input logic [4:0] op, input logic imm,
                                      input logic [3:0] rd, input logic [3:0] rs1,
                                      input logic [3:0] rs2);
    return {op, imm, rd, rs1, rs2, 14'd0};
  endfunction

  task automatic check(input string nm, input int id, input int d,
                       input logic [47:0] got, input logic [47:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL v%0d dut%0d %s got=%0h want=%0h", id, d, nm, got, want);
    end
  endtask

  // Apply one cycle of stimulus; optionally queue its expectation, then
  // advance the bench's own stall-count model from the expected hold_OF.
  task automatic step(input int id, input logic r,
                      input logic vo, input logic [31:0] io,
                      input logic ve, input logic [31:0] ie,
                      input logic vm, input logic [31:0] im,
                      input logic vw, input logic [31:0] iw,
                      input logic b, input logic chk, input logic [8:0] f,
                      input logic [5:0] ca, input logic [5:0] cb, input logic [5:0] cc);
    exp_t e;
    logic [5:0] cv [3];
    @(posedge clk);
    #1;
    rst = r; v_of = vo; i_of = io; v_ex = ve; i_ex = ie;
    v_ma = vm; i_ma = im; v_wb = vw; i_wb = iw; br = b;
    if (chk) begin
      e.id = id; e.fwd = f; e.ctrl = {ca, cb, cc};
      e.cnt = {mcnt[0], mcnt[1], mcnt[2]};
      sb.push_back(e);
    end
    cv[0] = ca; cv[1] = cb; cv[2] = cc;
    for (int d = 0; d < 3; d++) begin
      if (r) mcnt[d] = 16'd0;
      else if (cv[d][4] && (mcnt[d] != 16'hFFFF)) mcnt[d] = mcnt[d] + 16'd1;
    end
  endtask

  // monitor: every cycle with a queued expectation is compared on the negedge
  always @(negedge clk) begin
    if (sb.size() > 0) begin : mon
      exp_t e;
      e = sb.pop_front();
      for (int d = 0; d < 3; d++) begin
        check("fwd", e.id, d, 48'({of1[d], of2[d], exr1[d], exr2[d], exst[d], mas[d]}), 48'(e.fwd));
        check("ctrl", e.id, d, 48'({hif[d], hof[d], hex[d], bex[d], bma[d], fof[d]}),
              48'(e.ctrl[17-6*d -: 6]));
        check("stall_cycles", e.id, d, 48'(sc[d]), 48'(e.cnt[47-16*d -: 16]));
      end
    end
  end

  initial begin
    logic [31:0] nop_i, add3, add3b, sub533, sub533i, ld3, ld4, add64i, ld2;
    logic [31:0] add522, add512, mul9, div9, st46, add4, add6, st7, ld7, add877;
    logic [31:0] call_i, ret_i, nopr3;
    nop_i   = enc(OP_NOP, 1'b0, 4'd0, 4'd0, 4'd0);
    nopr3   = enc(OP_NOP, 1'b0, 4'd3, 4'd0, 4'd0);
    add3    = enc(OP_ADD, 1'b0, 4'd3, 4'd1, 4'd2);
    add3b   = enc(OP_ADD, 1'b0, 4'd3, 4'd7, 4'd8);
    sub533  = enc(OP_SUB, 1'b0, 4'd5, 4'd3, 4'd3);
    sub533i = enc(OP_SUB, 1'b1, 4'd5, 4'd3, 4'd3);
    ld3     = enc(OP_LD,  1'b0, 4'd3, 4'd1, 4'd0);
    ld4     = enc(OP_LD,  1'b0, 4'd4, 4'd1, 4'd0);
    ld2     = enc(OP_LD,  1'b0, 4'd2, 4'd1, 4'd0);
    add64i  = enc(OP_ADD, 1'b1, 4'd6, 4'd4, 4'd0);
    add522  = enc(OP_ADD, 1'b0, 4'd5, 4'd2, 4'd2);
    add512  = enc(OP_ADD, 1'b0, 4'd5, 4'd1, 4'd2);
    mul9    = enc(OP_MUL, 1'b0, 4'd9, 4'd1, 4'd2);
    div9    = enc(OP_DIV, 1'b0, 4'd9, 4'd1, 4'd2);
    st46    = enc(OP_ST,  1'b0, 4'd4, 4'd6, 4'd6);
    add4    = enc(OP_ADD, 1'b0, 4'd4, 4'd1, 4'd1);
    add6    = enc(OP_ADD, 1'b0, 4'd6, 4'd1, 4'd1);
    st7     = enc(OP_ST,  1'b0, 4'd7, 4'd1, 4'd0);
    ld7     = enc(OP_LD,  1'b0, 4'd7, 4'd1, 4'd0);
    add877  = enc(OP_ADD, 1'b0, 4'd8, 4'd7, 4'd7);
    call_i  = enc(OP_CALL, 1'b0, 4'd0, 4'd0, 4'd0);
    ret_i   = enc(OP_RET,  1'b0, 4'd0, 4'd0, 4'd0);

    rst = 1'b1; br = 1'b0;
    v_of = 1'b0; v_ex = 1'b0; v_ma = 1'b0; v_wb = 1'b0;
    i_of = 32'd0; i_ex = 32'd0; i_ma = 32'd0; i_wb = 32'd0;
    for (int d = 0; d < 3; d++) mcnt[d] = 16'd0;

    // id rst  OF           EX            MA           WB          br  chk fwd             A   B   C
    step( 0, 1'b1, 1'b0, nop_i, 1'b0, nop_i,   1'b0, nop_i, 1'b0, nop_i, 1'b0, 1'b0, 9'b0_0_00_00_00_0, Z, Z, Z);
    step( 1, 1'b0, 1'b0, nop_i, 1'b0, nop_i,   1'b0, nop_i, 1'b0, nop_i, 1'b0, 1'b1, 9'b0_0_00_00_00_0, Z, Z, Z);
    // MA beats WB on both operands
    step( 2, 1'b0, 1'b1, nop_i, 1'b1, sub533,  1'b1, add3,  1'b1, add3b, 1'b0, 1'b1, 9'b0_0_01_01_00_0, Z, Z, Z);
    // invalid MA is not a source
    step( 3, 1'b0, 1'b1, nop_i, 1'b1, sub533,  1'b0, add3,  1'b1, add3b, 1'b0, 1'b1, 9'b0_0_10_10_00_0, Z, Z, Z);
    // ld in MA is not a source to EX
    step( 4, 1'b0, 1'b1, nop_i, 1'b1, sub533,  1'b1, ld3,   1'b1, add3b, 1'b0, 1'b1, 9'b0_0_10_10_00_0, Z, Z, Z);
    // immediate form: no rs2 read; nop in WB is not a writer
    step( 5, 1'b0, 1'b0, nop_i, 1'b1, sub533i, 1'b1, add3,  1'b1, nopr3, 1'b0, 1'b1, 9'b0_0_01_00_00_0, Z, Z, Z);
    // st in EX: data from MA, address from WB
    step( 6, 1'b0, 1'b0, nop_i, 1'b1, st46,    1'b1, add4,  1'b1, add6,  1'b0, 1'b1, 9'b0_0_10_00_01_0, Z, Z, Z);
    // WB ld feeds OF operands and MA store data
    step( 7, 1'b0, 1'b1, add877, 1'b0, nop_i,  1'b1, st7,   1'b1, ld7,   1'b0, 1'b1, 9'b1_1_00_00_00_1, Z, Z, Z);
    // call in WB, ret in OF: ra on rs1 path only
    step( 8, 1'b0, 1'b1, ret_i, 1'b0, nop_i,   1'b0, nop_i, 1'b1, call_i, 1'b0, 1'b1, 9'b1_0_00_00_00_0, Z, Z, Z);
    // load-use, then ld drains through MA to WB
    step( 9, 1'b0, 1'b1, add64i, 1'b1, ld4,    1'b0, nop_i, 1'b0, nop_i, 1'b0, 1'b1, 9'b0_0_00_00_00_0, LU, LU, LU);
    step(10, 1'b0, 1'b1, add64i, 1'b0, nop_i,  1'b1, ld4,   1'b0, nop_i, 1'b0, 1'b1, 9'b0_0_00_00_00_0, Z, Z, Z);
    step(11, 1'b0, 1'b1, add64i, 1'b0, nop_i,  1'b0, nop_i, 1'b1, ld4,   1'b0, 1'b1, 9'b1_0_00_00_00_0, Z, Z, Z);
    // taken branch suppresses load-use; then rs2 load-use without branch
    step(12, 1'b0, 1'b1, add522, 1'b1, ld2,    1'b0, nop_i, 1'b0, nop_i, 1'b1, 1'b1, 9'b0_0_00_00_00_0, BR, BR, BR);
    step(13, 1'b0, 1'b1, add512, 1'b1, ld2,    1'b0, nop_i, 1'b0, nop_i, 1'b0, 1'b1, 9'b0_0_00_00_00_0, LU, LU, LU);
    // mul held in EX four cycles, then EX empty
    step(14, 1'b0, 1'b0, nop_i, 1'b1, mul9,    1'b0, nop_i, 1'b0, nop_i, 1'b0, 1'b1, 9'b0_0_00_00_00_0, MD, Z, MD);
    step(15, 1'b0, 1'b0, nop_i, 1'b1, mul9,    1'b0, nop_i, 1'b0, nop_i, 1'b0, 1'b1, 9'b0_0_00_00_00_0, MD, Z, MD);
    step(16, 1'b0, 1'b0, nop_i, 1'b1, mul9,    1'b0, nop_i, 1'b0, nop_i, 1'b0, 1'b1, 9'b0_0_00_00_00_0, MD, Z, MD);
    step(17, 1'b0, 1'b0, nop_i, 1'b1, mul9,    1'b0, nop_i, 1'b0, nop_i, 1'b0, 1'b1, 9'b0_0_00_00_00_0, Z, Z, MD);
    step(18, 1'b0, 1'b0, nop_i, 1'b0, nop_i,   1'b0, nop_i, 1'b0, nop_i, 1'b0, 1'b1, 9'b0_0_00_00_00_0, Z, Z, MD);
    step(19, 1'b0, 1'b0, nop_i, 1'b0, nop_i,   1'b0, nop_i, 1'b0, nop_i, 1'b0, 1'b1, 9'b0_0_00_00_00_0, Z, Z, Z);
    // div, reset in its second cycle, then idle and a fresh div
    step(20, 1'b0, 1'b0, nop_i, 1'b1, div9,    1'b0, nop_i, 1'b0, nop_i, 1'b0, 1'b1, 9'b0_0_00_00_00_0, MD, Z, MD);
    step(21, 1'b1, 1'b0, nop_i, 1'b1, div9,    1'b0, nop_i, 1'b0, nop_i, 1'b0, 1'b1, 9'b0_0_00_00_00_0, MD, Z, MD);
    step(22, 1'b0, 1'b0, nop_i, 1'b0, nop_i,   1'b0, nop_i, 1'b0, nop_i, 1'b0, 1'b1, 9'b0_0_00_00_00_0, Z, Z, Z);
    step(23, 1'b0, 1'b0, nop_i, 1'b1, div9,    1'b0, nop_i, 1'b0, nop_i, 1'b0, 1'b1, 9'b0_0_00_00_00_0, MD, Z, MD);

    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
